// File: rtl/mmio_monitor.sv
// MMIO print/exit monitor: per-channel print FIFOs drained by a round-robin stream, plus a
// done/exit-code latch and a status map. Optional watchdog enabled by MMIO_MONITOR_TIMEOUT_EN.
module mmio_monitor #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           NUM_CHANNELS   = 4,
    parameter int unsigned           FIFO_DEPTH     = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'hFFFF_0000,
    parameter int unsigned           TIMEOUT_CYCLES = 10000,
    localparam int unsigned          CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    memory_write_enable,
    input  logic                    memory_read_enable,
    input  logic [ADDR_WIDTH-1:0]   memory_address,
    input  logic [DATA_WIDTH-1:0]   memory_write_data,
    output logic [DATA_WIDTH-1:0]   memory_read_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CW-1:0]           out_channel,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   exit_code,
    output logic                    timeout,
    output logic [NUM_CHANNELS-1:0] overflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = PW + 1;

    logic [DATA_WIDTH-1:0]   mem_q  [NUM_CHANNELS][FIFO_DEPTH];
    logic [PW-1:0]           wptr_q [NUM_CHANNELS];
    logic [PW-1:0]           rptr_q [NUM_CHANNELS];
    logic [NW-1:0]           cnt_q  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] overflow_q, overflow_d;
    logic                    done_q;
    logic [DATA_WIDTH-1:0]   exit_code_q;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [CW-1:0]           rr_ptr_q;
    logic [CW-1:0]           grant_q;
    logic                    lock_q;

    logic [ADDR_WIDTH-1:0]   offset;
    logic                    ch_wr, wr_done, wr_clr;
    logic [CW-1:0]           push_ch;
    logic [NUM_CHANNELS-1:0] nonempty, push_v, pop_v, full_v, acc_v, ovf_set;
    logic [NUM_CHANNELS-1:0] clr_mask;
    logic [CW:0]             cand;
    logic [CW-1:0]           pick, cur_ch;
    logic                    found, pop;
    logic [DATA_WIDTH-1:0]   status;

    assign offset  = memory_address - BASE_ADDR;
    assign ch_wr   = memory_write_enable && (offset < ADDR_WIDTH'(4 * NUM_CHANNELS))
                     && (offset[1:0] == 2'b00);
    assign push_ch = offset[CW+1:2];
    assign wr_done = memory_write_enable && (offset == ADDR_WIDTH'(32'h40));
    assign wr_clr  = memory_write_enable && (offset == ADDR_WIDTH'(32'h48));

    // Round-robin search starting at rr_ptr_q, which points one past the last granted channel.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            nonempty[i] = (cnt_q[i] != '0);
        end
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            cand = {1'b0, rr_ptr_q} + (CW+1)'(k);
            if (cand >= (CW+1)'(NUM_CHANNELS)) begin
                cand = cand - (CW+1)'(NUM_CHANNELS);
            end
            if (!found && nonempty[cand[CW-1:0]]) begin
                found = 1'b1;
                pick  = cand[CW-1:0];
            end
        end
    end

    // Once presented and stalled, the grant is locked so channel/data hold until the handshake.
    assign cur_ch      = lock_q ? grant_q : pick;
    assign out_valid   = lock_q || found;
    assign out_channel = cur_ch;
    assign out_data    = out_valid ? mem_q[cur_ch][rptr_q[cur_ch]] : '0;
    assign pop         = out_valid && out_ready;

    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            push_v[i]  = ch_wr && (push_ch == CW'(i));
            pop_v[i]   = pop && (cur_ch == CW'(i));
            full_v[i]  = (cnt_q[i] == NW'(FIFO_DEPTH));
            acc_v[i]   = push_v[i] && (!full_v[i] || pop_v[i]);
            ovf_set[i] = push_v[i] && full_v[i] && !pop_v[i];
        end
        clr_mask   = wr_clr ? memory_write_data[NUM_CHANNELS-1:0] : '0;
        overflow_d = (overflow_q & ~clr_mask) | ovf_set;
    end

    always_comb begin
        status                 = '0;
        status[DATA_WIDTH-1]   = done_q;
        status[DATA_WIDTH-2]   = timeout;
        status[NUM_CHANNELS-1:0] = overflow_q;
        rdata_d                = rdata_q;
        if (memory_read_enable) begin
            if (offset == ADDR_WIDTH'(32'h44)) begin
                rdata_d = status;
            end else if (offset == ADDR_WIDTH'(32'h4C)) begin
                rdata_d = DATA_WIDTH'(nonempty);
            end else begin
                rdata_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (acc_v[i]) begin
                mem_q[i][wptr_q[i]] <= memory_write_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            overflow_q  <= '0;
            done_q      <= 1'b0;
            exit_code_q <= '0;
            rdata_q     <= '0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            lock_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (acc_v[i]) begin
                    wptr_q[i] <= wptr_q[i] + 1'b1;
                end
                if (pop_v[i]) begin
                    rptr_q[i] <= rptr_q[i] + 1'b1;
                end
                cnt_q[i] <= cnt_q[i] + NW'(acc_v[i]) - NW'(pop_v[i]);
            end
            overflow_q <= overflow_d;
            rdata_q    <= rdata_d;
            if (wr_done && !done_q) begin
                done_q      <= 1'b1;
                exit_code_q <= memory_write_data;
            end
            if (pop) begin
                lock_q   <= 1'b0;
                rr_ptr_q <= (cur_ch == CW'(NUM_CHANNELS - 1)) ? '0 : cur_ch + 1'b1;
            end else if (out_valid) begin
                lock_q  <= 1'b1;
                grant_q <= cur_ch;
            end
        end
    end

`ifdef MMIO_MONITOR_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wd_cnt_q;
    logic          timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else if (!done_q && !timeout_q) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
            if (wd_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign memory_read_data = rdata_q;
    assign done             = done_q;
    assign exit_code        = exit_code_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_mmio_monitor.sv
// Scoreboard bench for mmio_monitor: print data is queued when written and retired on handshakes.
module tb_mmio_monitor;

    localparam int unsigned TMO  = 100;
    localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef MMIO_MONITOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk, rst;
    logic        memory_write_enable, memory_read_enable;
    logic [31:0] memory_address, memory_write_data, memory_read_data;
    logic        out_valid, out_ready;
    logic [1:0]  out_channel;
    logic [31:0] out_data;
    logic        done, timeout;
    logic [31:0] exit_code;
    logic [3:0]  overflow;

    mmio_monitor #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .memory_write_enable (memory_write_enable),
        .memory_read_enable  (memory_read_enable),
        .memory_address      (memory_address),
        .memory_write_data   (memory_write_data),
        .memory_read_data    (memory_read_data),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_channel         (out_channel),
        .out_data            (out_data),
        .done                (done),
        .exit_code           (exit_code),
        .timeout             (timeout),
        .overflow            (overflow)
    );

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] d;
    } sb_t;

    sb_t         sb[$];
    int          ord_q[$];
    int          errors = 0;
    int          checks = 0;
    int          pops = 0;
    int          mon_idx;
    int          cyc;
    logic        m_done;
    logic        exp_to;
    logic [31:0] rd;
    int          p0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference for done latch and watchdog expectation.
    always @(posedge clk) begin
        if (rst) begin
            cyc    <= 0;
            m_done <= 1'b0;
        end else begin
            if (!m_done && cyc < TMO) cyc <= cyc + 1;
            if (memory_write_enable && memory_address == BASE + 32'h40) m_done <= 1'b1;
        end
    end
    assign exp_to = TO_EN && (cyc >= TMO);

    function automatic logic [31:0] status_exp(input logic [3:0] ov);
        return {m_done, exp_to, 26'd0, ov};
    endfunction

    // Retire one entry per handshake; data must match in per-channel order.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            pops++;
            mon_idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
                if (mon_idx < 0 && sb[i].ch == out_channel) mon_idx = i;
            end
            check_val("sb_channel_known", 32'(mon_idx >= 0), 32'd1);
            if (mon_idx >= 0) begin
                check_val("sb_data", out_data, sb[mon_idx].d);
                sb.delete(mon_idx);
            end
            if (ord_q.size() > 0) begin
                check_val("rr_order", 32'(out_channel), 32'(ord_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        memory_address      = a;
        memory_write_data   = d;
        memory_write_enable = 1'b1;
        tick(1);
        memory_write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        memory_address     = a;
        memory_read_enable = 1'b1;
        tick(1);
        memory_read_enable = 1'b0;
        d = memory_read_data;
    endtask

    task automatic print(input int ch, input logic [31:0] d, input bit acc);
        sb_t e;
        e.ch = 2'(ch);
        e.d  = d;
        if (acc) sb.push_back(e);
        bus_write(BASE + 32'(4 * ch), d);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
        tick(1);
        check_val("drain_empty", 32'(sb.size()), 32'd0);
        check_val("drain_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        ord_q.delete();
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 500000", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        memory_write_enable = 1'b0;
        memory_read_enable  = 1'b0;
        memory_address      = '0;
        memory_write_data   = '0;
        out_ready           = 1'b0;
        tick(3);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_data", out_data, 32'd0);
        check_val("rst_out_channel", 32'(out_channel), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_exit_code", exit_code, 32'd0);
        check_val("rst_timeout", 32'(timeout), 32'd0);
        check_val("rst_overflow", 32'(overflow), 32'd0);
        check_val("rst_read_data", memory_read_data, 32'd0);
        rst = 1'b0;

        // Watchdog: high exactly on the TMO-th post-reset edge when enabled.
        tick(TMO - 1);
        check_val("timeout_before", 32'(timeout), 32'd0);
        tick(1);
        check_val("timeout_at_limit", 32'(timeout), 32'(TO_EN));
        bus_read(BASE + 32'h44, rd);
        check_val("timeout_status", rd, status_exp(4'b0000));
        do_reset();

        // Accesses outside the map change nothing.
        bus_write(BASE + 32'h10, 32'h1);
        bus_write(BASE + 32'h50, 32'h1);
        bus_write(BASE - 32'h4, 32'h1);
        bus_read(BASE + 32'h4C, rd);
        check_val("unmapped_mask", rd, 32'd0);
        bus_read(BASE + 32'h50, rd);
        check_val("unmapped_read", rd, 32'd0);
        check_val("unmapped_done", 32'(done), 32'd0);

        // Single print with ready high.
        out_ready = 1'b1;
        print(0, 32'h2A, 1'b1);
        check_val("single_valid", 32'(out_valid), 32'd1);
        check_val("single_channel", 32'(out_channel), 32'd0);
        check_val("single_data", out_data, 32'h2A);
        tick(1);
        check_val("single_valid_after", 32'(out_valid), 32'd0);
        check_val("single_sb_empty", 32'(sb.size()), 32'd0);

        // Overflow on the ninth push into a stalled depth-8 FIFO, then W1C.
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) print(1, 32'h100 + 32'(k), k < 8);
        check_val("ovf_bits", 32'(overflow), 32'h2);
        bus_read(BASE + 32'h44, rd);
        check_val("ovf_status", rd, status_exp(4'b0010));
        bus_read(BASE + 32'h4C, rd);
        check_val("ovf_mask", rd, 32'h2);
        bus_write(BASE + 32'h48, 32'h2);
        check_val("ovf_w1c", 32'(overflow), 32'd0);
        drain();

        // Round-robin across channels 0, 2, 3.
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            int ch;
            ch = (k % 3 == 0) ? 0 : (k % 3 == 1) ? 2 : 3;
            ord_q.push_back(ch);
            print(ch, 32'h200 + 32'(k), 1'b1);
        end
        bus_read(BASE + 32'h4C, rd);
        check_val("rr_mask", rd, 32'hD);
        drain();
        check_val("rr_all_seen", 32'(ord_q.size()), 32'd0);

        // Push and pop on a full FIFO in the same cycle.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) print(0, 32'h300 + 32'(k), 1'b1);
        p0 = pops;
        out_ready = 1'b1;
        print(0, 32'h3FF, 1'b1);
        out_ready = 1'b0;
        check_val("full_pushpop_ovf", 32'(overflow), 32'd0);
        check_val("full_pushpop_pops", 32'(pops - p0), 32'd1);
        drain();
        check_val("full_pushpop_total", 32'(pops - p0), 32'd9);

        // Done latches the first exit code only.
        bus_write(BASE + 32'h40, 32'h5);
        bus_write(BASE + 32'h40, 32'h7);
        check_val("done_flag", 32'(done), 32'd1);
        check_val("exit_code", exit_code, 32'h5);
        bus_read(BASE + 32'h44, rd);
        check_val("done_status", rd, status_exp(4'b0000));
        check_val("timeout_out", 32'(timeout), 32'(exp_to));
        out_ready = 1'b1;
        print(3, 32'h77, 1'b1);
        drain();

        // Reset mid-stream discards queued data.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) print(2, 32'h400 + 32'(k), 1'b1);
        check_val("pre_rst_valid", 32'(out_valid), 32'd1);
        p0 = pops;
        rst = 1'b1;
        sb.delete();
        tick(1);
        check_val("rst_mid_valid", 32'(out_valid), 32'd0);
        check_val("rst_mid_data", out_data, 32'd0);
        check_val("rst_mid_done", 32'(done), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick(3);
        check_val("post_rst_valid", 32'(out_valid), 32'd0);
        check_val("post_rst_pops", 32'(pops - p0), 32'd0);
        bus_read(BASE + 32'h4C, rd);
        check_val("post_rst_mask", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
